// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state encoding and defaults shared by uart_tx_arbiter and rr_pick.
package uart_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } arb_state_t;

   localparam int unsigned TIMEOUT_CLKS_DEFAULT = 512;
   localparam int unsigned BYTE_W               = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker. Searches req from (last+1) mod NUM_REQ
// upward with wrap and returns the first set index.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic                       valid,
   output logic [$clog2(NUM_REQ)-1:0] idx
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   int unsigned cand;

   // Walk offsets from farthest to nearest so the nearest set bit after last wins
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int unsigned off = NUM_REQ; off >= 1; off--) begin
         cand = (32'(last) + off) % NUM_REQ;
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer among NUM_REQ byte sources.
// One byte per grant; o_Tx_Byte is held until the serializer's done pulse because uart_tx
// samples the byte at the end of its start bit.
// Optional macro UART_ARB_LOCK_EN adds i_Lock: a requester that completes a frame with its
// lock bit set wins its next request unconditionally, keeping multi-byte messages contiguous.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic [NUM_REQ-1:0]        i_Req,
   input  logic [BYTE_W*NUM_REQ-1:0] i_Data,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        i_Lock,
`endif
   output logic [NUM_REQ-1:0]        o_Ack,
   output logic                      o_Err,
   output logic                      o_Tx_DV,
   output logic [BYTE_W-1:0]         o_Tx_Byte,
   input  logic                      i_Tx_Active,
   input  logic                      i_Tx_Done
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);

   arb_state_t       state;
   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] idx;
   logic [TMR_W-1:0] timer;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             hold_off;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req   (i_Req),
      .last  (last),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Requesters are still updating i_Req/i_Data in the ack/err cycle, so no grant then
   assign hold_off = (|o_Ack) | o_Err;

`ifdef UART_ARB_LOCK_EN
   logic locked;

   // A locked requester (always the last one served) overrides round-robin when requesting
   always_comb begin
      grant_valid = pick_valid;
      grant_idx   = pick_idx;
      if (locked && i_Req[last]) begin
         grant_valid = 1'b1;
         grant_idx   = last;
      end
   end

   // Lock follows the i_Lock bit at done; a timeout always releases it
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         locked <= 1'b0;
      end else if (state == S_WAIT) begin
         if (i_Tx_Done) begin
            locked <= i_Lock[idx];
         end else if (timer == TMR_W'(TIMEOUT_CLKS - 1)) begin
            locked <= 1'b0;
         end
      end
   end
`else
   assign grant_valid = pick_valid;
   assign grant_idx   = pick_idx;
`endif

   // Arbiter FSM with registered strobes, byte register and abort timer
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state     <= S_IDLE;
         last      <= IDX_W'(NUM_REQ - 1);
         idx       <= '0;
         timer     <= '0;
         o_Ack     <= '0;
         o_Err     <= 1'b0;
         o_Tx_DV   <= 1'b0;
         o_Tx_Byte <= '0;
      end else begin
         o_Ack   <= '0;
         o_Err   <= 1'b0;
         o_Tx_DV <= 1'b0;
         case (state)
            S_IDLE: begin
               // Waiting on i_Tx_Active also covers a frame left running across reset
               if (grant_valid && !i_Tx_Active && !hold_off) begin
                  idx       <= grant_idx;
                  o_Tx_Byte <= i_Data[{grant_idx, 3'b000} +: BYTE_W];
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               o_Tx_DV <= 1'b1;
               timer   <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (i_Tx_Done) begin
                  o_Ack[idx] <= 1'b1;
                  last       <= idx;
                  state      <= S_IDLE;
               end else if (timer == TMR_W'(TIMEOUT_CLKS - 1)) begin
                  o_Err <= 1'b1;
                  last  <= idx;
                  state <= S_IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
